// File: rtl/ddr3_test_traffic_gen.sv
// Avalon-MM write-then-read traffic generator for DDR3 bring-up.
// Writes pattern(A) to word addresses 0..LAST_ADDR, then reads them back in order.
//
// state         | meaning
// --------------+---------------------------------------------------
// WAIT_FOR_INIT | waiting for controller init and calibration result
// WRITE         | issuing pattern writes, one per accept
// TURNAROUND    | single idle cycle between write and read phases
// READ          | issuing reads, throttled by the outstanding count
// DRAIN         | all reads issued, waiting for outstanding data
// DONE          | test traffic complete, idle until reset
// ERROR         | calibration failure or protocol violation
module ddr3_test_traffic_gen #(
  parameter int unsigned           ADDR_WIDTH      = 25,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR       = ADDR_WIDTH'(32'h0100_0000),
  parameter int unsigned           MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ddr3_init_done,
  input  logic                  ddr3_cal_success,
  input  logic                  ddr3_cal_fail,
  input  logic                  avl_ready,
  input  logic                  avl_rdata_valid,
  output logic                  avl_burstbegin,
  output logic [ADDR_WIDTH-1:0] avl_addr,
  output logic [63:0]           avl_wdata,
  output logic [7:0]            avl_be,
  output logic [2:0]            avl_size,
  output logic                  avl_write_req,
  output logic                  avl_read_req,
  output logic                  writes_done,
  output logic                  reads_issued,
  output logic                  error
);

  localparam logic [63:0] PATTERN_SEED = 64'hdeadfadebabebeef;

  typedef enum logic [2:0] {
    S_WAIT_FOR_INIT = 3'd0,
    S_WRITE         = 3'd1,
    S_TURNAROUND    = 3'd2,
    S_READ          = 3'd3,
    S_DRAIN         = 3'd4,
    S_DONE          = 3'd5,
    S_ERROR         = 3'd6
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [3:0]            outstanding, outstanding_nxt;
  logic                  wr_accept, rd_accept;
  logic                  set_writes_done, set_reads_issued;

  assign avl_be    = 8'hff;
  assign avl_size  = 3'd1;
  assign wr_accept = avl_write_req & avl_ready;
  assign rd_accept = avl_read_req & avl_ready;

  always_comb begin
    state_nxt        = state;
    addr_nxt         = avl_addr;
    outstanding_nxt  = outstanding;
    set_writes_done  = 1'b0;
    set_reads_issued = 1'b0;

    case (state)
      S_WAIT_FOR_INIT: begin
        if (ddr3_init_done && ddr3_cal_success)   state_nxt = S_WRITE;
        else if (ddr3_init_done && ddr3_cal_fail) state_nxt = S_ERROR;
      end
      S_WRITE: begin
        if (wr_accept) begin
          if (avl_addr == LAST_ADDR) begin
            addr_nxt        = '0;
            set_writes_done = 1'b1;
            state_nxt       = S_TURNAROUND;
          end else begin
            addr_nxt = avl_addr + ADDR_WIDTH'(1);
          end
        end
      end
      S_TURNAROUND: state_nxt = S_READ;
      S_READ: begin
        if (rd_accept) begin
          if (avl_addr == LAST_ADDR) begin
            set_reads_issued = 1'b1;
            state_nxt        = S_DRAIN;
          end else begin
            addr_nxt = avl_addr + ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: if (outstanding == 4'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_ERROR;
    endcase

    if (state == S_READ || state == S_DRAIN) begin
      if (rd_accept && !avl_rdata_valid)      outstanding_nxt = outstanding + 4'd1;
      else if (!rd_accept && avl_rdata_valid) outstanding_nxt = outstanding - 4'd1;
    end

    // Returned data with nothing in flight, or before reads could exist, is a protocol error.
    if (avl_rdata_valid &&
        (outstanding == 4'd0 || state inside {S_WAIT_FOR_INIT, S_WRITE, S_TURNAROUND}))
      state_nxt = S_ERROR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_WAIT_FOR_INIT;
      outstanding    <= 4'd0;
      avl_addr       <= '0;
      avl_wdata      <= 64'd0;
      avl_write_req  <= 1'b0;
      avl_read_req   <= 1'b0;
      avl_burstbegin <= 1'b0;
      writes_done    <= 1'b0;
      reads_issued   <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_nxt;
      outstanding    <= outstanding_nxt;
      avl_addr       <= addr_nxt;
      avl_wdata      <= PATTERN_SEED ^ {{(64-ADDR_WIDTH){1'b0}}, addr_nxt};
      avl_write_req  <= (state_nxt == S_WRITE);
      avl_read_req   <= (state_nxt == S_READ) && (outstanding_nxt < 4'(MAX_OUTSTANDING));
      avl_burstbegin <= (state_nxt == S_WRITE) ||
                        ((state_nxt == S_READ) && (outstanding_nxt < 4'(MAX_OUTSTANDING)));
      writes_done    <= writes_done | set_writes_done;
      reads_issued   <= reads_issued | set_reads_issued;
      error          <= error | (state_nxt == S_ERROR);
    end
  end

endmodule

// File: tb/tb_ddr3_test_traffic_gen.sv
// Scoreboard bench for ddr3_test_traffic_gen: expected requests are queued by the
// stimulus and popped by a monitor on every accepted request.
`timescale 1ns/1ps
module tb_ddr3_test_traffic_gen;
  localparam int          AW   = 25;
  localparam int          LAST = 15;
  localparam int          MAXO = 4;
  localparam logic [63:0] SEED = 64'hdeadfadebabebeef;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ddr3_init_done = 1'b0, ddr3_cal_success = 1'b0, ddr3_cal_fail = 1'b0;
  logic          avl_ready = 1'b0;
  logic          avl_rdata_valid = 1'b0;
  logic          avl_burstbegin, avl_write_req, avl_read_req;
  logic [AW-1:0] avl_addr;
  logic [63:0]   avl_wdata;
  logic [7:0]    avl_be;
  logic [2:0]    avl_size;
  logic          avl_writes_done, avl_reads_issued, avl_error;

  ddr3_test_traffic_gen #(
    .ADDR_WIDTH(AW), .LAST_ADDR(AW'(LAST)), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ddr3_init_done(ddr3_init_done), .ddr3_cal_success(ddr3_cal_success),
    .ddr3_cal_fail(ddr3_cal_fail), .avl_ready(avl_ready),
    .avl_rdata_valid(avl_rdata_valid), .avl_burstbegin(avl_burstbegin),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_size(avl_size),
    .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .writes_done(avl_writes_done), .reads_issued(avl_reads_issued), .error(avl_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } txn_t;

  txn_t  exp_q[$];
  int    due_q[$];
  int    cyc = 0;
  int    n_checks = 0, n_fail = 0;
  int    wr_n = 0, rd_n = 0, req_cycles = 0;
  int    first_wr_cyc = 0, last_wr_cyc = 0, first_rd_cyc = 0;
  logic  hold = 1'b0, spurious = 1'b0;
  logic  wd_pend = 1'b0, ri_pend = 1'b0, stall_v = 1'b0;
  logic [26:0] stall_ctl = '0;
  logic [63:0] stall_data = '0;
  txn_t  mon_t;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      stall_v = 1'b0; wd_pend = 1'b0; ri_pend = 1'b0;
      wr_n = 0; rd_n = 0;
    end else begin
      if (avl_write_req | avl_read_req) req_cycles++;
      if (wd_pend) begin check("writes_done_rise", 64'(avl_writes_done), 64'd1); wd_pend = 1'b0; end
      if (ri_pend) begin check("reads_issued_rise", 64'(avl_reads_issued), 64'd1); ri_pend = 1'b0; end
      check("req_exclusive", 64'(avl_write_req & avl_read_req), 64'd0);
      if (stall_v && !avl_error) begin
        check("stall_hold_ctl", 64'({avl_write_req, avl_read_req, avl_addr}), 64'(stall_ctl));
        check("stall_hold_data", avl_wdata, stall_data);
      end
      stall_v    = (avl_write_req | avl_read_req) && !avl_ready;
      stall_ctl  = {avl_write_req, avl_read_req, avl_addr};
      stall_data = avl_wdata;
      if ((avl_write_req | avl_read_req) && avl_ready) begin
        check("burstbegin", 64'(avl_burstbegin), 64'd1);
        check("avl_be", 64'(avl_be), 64'hff);
        check("avl_size", 64'(avl_size), 64'd1);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_request: wr=%0b rd=%0b addr=0x%0h, expected no request",
                   avl_write_req, avl_read_req, avl_addr);
        end else begin
          mon_t = exp_q.pop_front();
          check("req_type_write", 64'(avl_write_req), 64'(mon_t.wr));
          check("req_addr", 64'(avl_addr), 64'(mon_t.addr));
          if (mon_t.wr) check("wdata", avl_wdata, mon_t.data);
        end
        if (avl_write_req) begin
          if (wr_n == 0) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
          wr_n++;
          if (avl_addr == AW'(LAST)) begin
            check("writes_done_early", 64'(avl_writes_done), 64'd0);
            wd_pend = 1'b1;
          end
        end
        if (avl_read_req) begin
          if (rd_n == 0) first_rd_cyc = cyc;
          rd_n++;
          due_q.push_back(cyc + 4);
          if (avl_addr == AW'(LAST)) ri_pend = 1'b1;
        end
      end
    end
  end

  // Read-data responder: returns one word per cycle once due, unless withheld
  initial forever begin
    @(posedge clk); #2;
    if (!reset_n) begin
      due_q.delete();
      avl_rdata_valid = 1'b0;
    end else if (!hold && due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      avl_rdata_valid = 1'b1;
    end else begin
      avl_rdata_valid = spurious;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_write_req"}, 64'(avl_write_req), 64'd0);
    check({tag, "_read_req"}, 64'(avl_read_req), 64'd0);
    check({tag, "_burstbegin"}, 64'(avl_burstbegin), 64'd0);
    check({tag, "_addr"}, 64'(avl_addr), 64'd0);
    check({tag, "_wdata"}, avl_wdata, 64'd0);
    check({tag, "_flags"}, 64'({avl_writes_done, avl_reads_issued, avl_error}), 64'd0);
    check({tag, "_be_size"}, 64'({avl_be, avl_size}), 64'({8'hff, 3'd1}));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; ddr3_cal_fail = 1'b0;
    avl_ready = 1'b0; hold = 1'b0; spurious = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic push_writes();
    txn_t t;
    for (int a = 0; a <= LAST; a++) begin
      t.wr = 1'b1; t.addr = AW'(a); t.data = SEED ^ 64'(a);
      if (a == 3) t.data = 64'hdeadfadebabebeec;
      exp_q.push_back(t);
    end
  endtask

  task automatic push_reads(input int n);
    txn_t t;
    for (int a = 0; a < n; a++) begin
      t.wr = 1'b0; t.addr = AW'(a); t.data = 64'd0;
      exp_q.push_back(t);
    end
  endtask

  task automatic wait_done(input int budget, input string name, input bit rand_rdy);
    int n = 0;
    while (!(avl_reads_issued && exp_q.size() == 0 && due_q.size() == 0) && n < budget) begin
      if (rand_rdy) avl_ready = ($urandom_range(0, 9) < 3);
      tick(1);
      n++;
    end
    if (n >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: %0d cycles elapsed, expected completion within %0d", name, n, budget);
    end
    avl_ready = 1'b1;
    tick(4);
    check({name, "_flags"}, 64'({avl_writes_done, avl_reads_issued, avl_error}), 64'b110);
    check({name, "_idle"}, 64'({avl_write_req, avl_read_req}), 64'd0);
    check({name, "_wr_count"}, 64'(wr_n), 64'(LAST + 1));
    check({name, "_rd_count"}, 64'(rd_n), 64'(LAST + 1));
  endtask

  initial begin
    int n, rc;
    // Reset values
    tick(3);
    check_reset_vals("por");
    reset_n = 1'b1;
    tick(1);

    // Calibration failure
    do_reset();
    rc = req_cycles;
    ddr3_init_done = 1'b1; ddr3_cal_fail = 1'b1;
    tick(1);
    check("calfail_error", 64'(avl_error), 64'd1);
    tick(6);
    check("calfail_no_requests", 64'(req_cycles - rc), 64'd0);
    check("calfail_error_sticky", 64'(avl_error), 64'd1);

    // Full pass, ready always high
    do_reset();
    push_writes(); push_reads(LAST + 1);
    avl_ready = 1'b1;
    ddr3_init_done = 1'b1; ddr3_cal_success = 1'b1;
    wait_done(600, "full", 1'b0);
    check("full_wr_back_to_back", 64'(last_wr_cyc - first_wr_cyc), 64'(LAST));
    check("full_turnaround_gap", 64'(first_rd_cyc - last_wr_cyc), 64'd2);

    // Backpressure, success and fail both high (success wins)
    do_reset();
    push_writes(); push_reads(LAST + 1);
    ddr3_init_done = 1'b1; ddr3_cal_success = 1'b1; ddr3_cal_fail = 1'b1;
    wait_done(3000, "bp", 1'b1);

    // Outstanding limit with data withheld
    do_reset();
    push_writes(); push_reads(LAST + 1);
    hold = 1'b1; avl_ready = 1'b1;
    ddr3_init_done = 1'b1; ddr3_cal_success = 1'b1;
    n = 0;
    while (!avl_writes_done && n < 100) begin tick(1); n++; end
    check("limit_writes_done", 64'(avl_writes_done), 64'd1);
    tick(12);
    check("limit_reads_accepted", 64'(rd_n), 64'(MAXO));
    check("limit_read_req_low", 64'(avl_read_req), 64'd0);
    hold = 1'b0;
    tick(1);
    check("limit_req_after_rdata", 64'(avl_read_req), 64'd1);
    wait_done(600, "limit", 1'b0);

    // Spurious rdata_valid during a stalled write
    do_reset();
    ddr3_init_done = 1'b1; ddr3_cal_success = 1'b1;
    tick(3);
    check("spur_write_presented", 64'({avl_write_req, avl_addr}), 64'({1'b1, 25'd0}));
    spurious = 1'b1;
    tick(1);
    spurious = 1'b0;
    tick(1);
    check("spur_error", 64'(avl_error), 64'd1);
    check("spur_req_drop", 64'({avl_write_req, avl_read_req, avl_burstbegin}), 64'd0);

    // Reset mid-READ with 3 reads outstanding, then full restart
    do_reset();
    push_writes(); push_reads(3);
    hold = 1'b1; avl_ready = 1'b1;
    ddr3_init_done = 1'b1; ddr3_cal_success = 1'b1;
    n = 0;
    while (rd_n < 3 && n < 200) begin tick(1); n++; end
    avl_ready = 1'b0;
    check("midrd_three_accepted", 64'(rd_n), 64'd3);
    tick(2);
    check("midrd_req_stalled", 64'(avl_read_req), 64'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midrd_rst");
    ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; hold = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    push_writes(); push_reads(LAST + 1);
    avl_ready = 1'b1;
    ddr3_init_done = 1'b1; ddr3_cal_success = 1'b1;
    wait_done(600, "restart", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time exceeded, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
